interleaver_deinterleaver_top: RTL and testbench

Byte-wide convolutional (Forney) interleaver followed directly by its matching deinterleaver, sharing one clock and one commutator. It is the loopback harness for the channel-coding path. Every clock one symbol enters the interleaver, and one symbol leaves each of the two outputs. The deinterleaver output reproduces the input stream after a fixed latency, which lets the pair be verified end to end.

---
 rtl/interleaver_deinterleaver_top.sv | 120 ++++++++++++
 tb/tb_interleaver_deinterleaver_top.sv | 102 ++++++++++
 2 files changed

// File: rtl/interleaver_deinterleaver_top.sv
// Forney convolutional interleaver looped straight into its matching deinterleaver.
// Optional macro ILV_SYNC_FLAG_EN adds deinterleaver_valid, driven by a saturating fill counter.
module interleaver_deinterleaver_top #(
  parameter int BRANCHES   = 4,
  parameter int UNIT_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] interleaver_input,
  output logic [3:0] select,
  output logic [7:0] interleaver_output,
  output logic [7:0] deinterleaver_output
`ifdef ILV_SYNC_FLAG_EN
  ,
  output logic       deinterleaver_valid
`endif
);

  localparam int MAXD = (BRANCHES - 1) * UNIT_DEPTH;
  localparam int PW   = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam int DA   = 1 << PW;

  logic [3:0]    select_q, select_d;
  logic [3:0]    sel_dly_q, sel_dly_d;
  logic [7:0]    ilv_out_q, ilv_out_d;
  logic [7:0]    dei_out_q, dei_out_d;

  // Per-branch circular buffers; rows exist only for branches with nonzero depth.
  logic [7:0]    ilv_mem_q [1:BRANCHES-1][DA];
  logic [7:0]    ilv_mem_d [1:BRANCHES-1][DA];
  logic [PW-1:0] ilv_ptr_q [1:BRANCHES-1];
  logic [PW-1:0] ilv_ptr_d [1:BRANCHES-1];
  logic [7:0]    dei_mem_q [0:BRANCHES-2][DA];
  logic [7:0]    dei_mem_d [0:BRANCHES-2][DA];
  logic [PW-1:0] dei_ptr_q [0:BRANCHES-2];
  logic [PW-1:0] dei_ptr_d [0:BRANCHES-2];

  always_comb begin
    select_d  = (select_q == 4'(BRANCHES - 1)) ? 4'd0 : select_q + 4'd1;
    sel_dly_d = select_q;

    ilv_mem_d = ilv_mem_q;
    ilv_ptr_d = ilv_ptr_q;
    ilv_out_d = interleaver_input;
    for (int i = 1; i < BRANCHES; i++) begin
      if (select_q == 4'(i)) begin
        ilv_out_d                   = ilv_mem_q[i][ilv_ptr_q[i]];
        ilv_mem_d[i][ilv_ptr_q[i]] = interleaver_input;
        ilv_ptr_d[i] = (ilv_ptr_q[i] == PW'(i * UNIT_DEPTH - 1)) ? '0
                                                                 : ilv_ptr_q[i] + PW'(1);
      end
    end

    // sel_dly matches the branch the symbol now in ilv_out_q was read from.
    dei_mem_d = dei_mem_q;
    dei_ptr_d = dei_ptr_q;
    dei_out_d = ilv_out_q;
    for (int j = 0; j < BRANCHES - 1; j++) begin
      if (sel_dly_q == 4'(j)) begin
        dei_out_d                   = dei_mem_q[j][dei_ptr_q[j]];
        dei_mem_d[j][dei_ptr_q[j]] = ilv_out_q;
        dei_ptr_d[j] = (dei_ptr_q[j] == PW'((BRANCHES - 1 - j) * UNIT_DEPTH - 1)) ? '0
                                                                                   : dei_ptr_q[j] + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      select_q  <= '0;
      sel_dly_q <= '0;
      ilv_out_q <= '0;
      dei_out_q <= '0;
      ilv_mem_q <= '{default: '0};
      ilv_ptr_q <= '{default: '0};
      dei_mem_q <= '{default: '0};
      dei_ptr_q <= '{default: '0};
    end else begin
      select_q  <= select_d;
      sel_dly_q <= sel_dly_d;
      ilv_out_q <= ilv_out_d;
      dei_out_q <= dei_out_d;
      ilv_mem_q <= ilv_mem_d;
      ilv_ptr_q <= ilv_ptr_d;
      dei_mem_q <= dei_mem_d;
      dei_ptr_q <= dei_ptr_d;
    end
  end

  assign select               = select_q;
  assign interleaver_output   = ilv_out_q;
  assign deinterleaver_output = dei_out_q;

`ifdef ILV_SYNC_FLAG_EN
  localparam int LAT = BRANCHES * (BRANCHES - 1) * UNIT_DEPTH + 2;
  localparam int CW  = $clog2(LAT) + 1;

  logic [CW-1:0] fill_cnt_q, fill_cnt_d;
  logic          valid_q, valid_d;

  // fill_cnt_q holds the number of edges since reset, saturating at LAT-1.
  always_comb begin
    fill_cnt_d = (fill_cnt_q == CW'(LAT - 1)) ? fill_cnt_q : fill_cnt_q + CW'(1);
    valid_d    = valid_q | (fill_cnt_q == CW'(LAT - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_cnt_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
      valid_q    <= valid_d;
    end
  end

  assign deinterleaver_valid = valid_q;
`endif

endmodule

// File: tb/tb_interleaver_deinterleaver_top.sv
// Bench for interleaver_deinterleaver_top: ramp stimulus, closed-form interleaver
// expectations and a latency queue scoreboard for the deinterleaver.
module tb_interleaver_deinterleaver_top;

  localparam int B   = 4;
  localparam int M   = 2;
  localparam int LAT = B * (B - 1) * M + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] interleaver_input;
  logic [3:0] select;
  logic [7:0] interleaver_output;
  logic [7:0] deinterleaver_output;
`ifdef ILV_SYNC_FLAG_EN
  logic       deinterleaver_valid;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] hist[$];
  logic [7:0] sb[$];

  interleaver_deinterleaver_top #(.BRANCHES(B), .UNIT_DEPTH(M)) dut (
    .clk                 (clk),
    .reset               (reset),
    .interleaver_input   (interleaver_input),
    .select              (select),
    .interleaver_output  (interleaver_output),
    .deinterleaver_output(deinterleaver_output)
`ifdef ILV_SYNC_FLAG_EN
    ,
    .deinterleaver_valid (deinterleaver_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    interleaver_input = 8'h00;
    #2;
    chk("rst_sel", {4'h0, select}, 8'h00);
    chk("rst_ilv", interleaver_output, 8'h00);
    chk("rst_dei", deinterleaver_output, 8'h00);
`ifdef ILV_SYNC_FLAG_EN
    chk("rst_valid", {7'h0, deinterleaver_valid}, 8'h00);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    hist.delete();
    sb.delete();
  endtask

  // k counts edges since reset release; the ramp restarts at 1 after every reset.
  task automatic run(input int n);
    logic [7:0] exp_ilv;
    logic [7:0] exp_dei;
    int         br;
    int         src;
    for (int k = 0; k < n; k++) begin
      interleaver_input = 8'(k + 1);
      hist.push_back(interleaver_input);
      sb.push_back(interleaver_input);
      @(posedge clk);
      #1;
      chk("sel", {4'h0, select}, 8'((k + 1) % B));
      br  = k % B;
      src = k - br * M * B;
      exp_ilv = (src >= 0) ? hist[src] : 8'h00;
      chk("ilv", interleaver_output, exp_ilv);
      exp_dei = (sb.size() == LAT) ? sb.pop_front() : 8'h00;
      chk("dei", deinterleaver_output, exp_dei);
`ifdef ILV_SYNC_FLAG_EN
      chk("valid", {7'h0, deinterleaver_valid}, (k >= LAT - 1) ? 8'h01 : 8'h00);
`endif
    end
  endtask

  initial begin
    reset = 1'b1;
    interleaver_input = 8'h00;
    do_reset();
    run(100);
    do_reset();
    run(500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
